pdm_sampler_mc: RTL and testbench

//   Multi-channel PDM front end for the DFE. Generates the microphone PDM clock from clk_i

---
 rtl/dfe_pdm_pkg.sv | 12 +
 rtl/pdm_clkgen.sv | 34 +++
 rtl/pdm_sampler_mc.sv | 78 +++++++
 tb/tb_pdm_sampler_mc.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dfe_pdm_pkg.sv
// dfe_pdm_pkg: shared edge-mode and side encodings for the PDM front end
package dfe_pdm_pkg;
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic SIDE_L = 1'b0;
    localparam logic SIDE_R = 1'b1;
    // reserved 11 shares the "both" behaviour, hence the bare mode[1] test
    function automatic logic edge_sel(input logic [1:0] mode, input logic is_fall);
        return mode[1] || mode == EDGE_BOTH || mode == (is_fall ? EDGE_FALL : EDGE_RISE);
    endfunction
endpackage

// File: rtl/pdm_clkgen.sv
// pdm_clkgen: runtime-divided PDM clock with glitch-free half-period latch and edge pulses
module pdm_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_i,
    output logic             pdm_clk,
    output logic             rise,
    output logic             fall,
    output logic [DIV_W-1:0] div_eff
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_new;
    logic             tick;
    assign div_new = div_i == '0 ? DIV_W'(1) : div_i;
    assign tick    = cnt == div_eff - DIV_W'(1);
    // half-period length only changes at a toggle, so a new div_i never shortens a pulse
    always_ff @(posedge clk_i) begin
        if (clr) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            div_eff <= div_new;
        end else begin
            cnt     <= tick ? '0 : cnt + DIV_W'(1);
            pdm_clk <= pdm_clk ^ tick;
            rise    <= tick && !pdm_clk;
            fall    <= tick && pdm_clk;
            div_eff <= tick ? div_new : div_eff;
        end
    end
endmodule

// File: rtl/pdm_sampler_mc.sv
// pdm_sampler_mc: multi-channel PDM sampler with delayed capture, valid/ready output and overrun flag
module pdm_sampler_mc
    import dfe_pdm_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int DLY_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [DLY_W-1:0]  dly_i,
    input  logic [1:0]        edge_mode_i,
    input  logic [NUM_CH-1:0] data_i,
    output logic              pdm_clk_o,
    output logic [NUM_CH-1:0] data_o,
    output logic              side_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              ovf_o
);
    localparam int W = DIV_W > DLY_W ? DIV_W : DLY_W;
    logic             clr, rise, fall, ev, pend, side_p, cap, cap_now, cap_side;
    logic [DIV_W-1:0] div_eff;
    logic [DLY_W-1:0] dly_eff, dcnt;
    logic [W-1:0]     dmax, dly_x;
    assign clr = rst_i || !en_i;
    pdm_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk_i   (clk_i),
        .clr     (clr),
        .div_i   (div_i),
        .pdm_clk (pdm_clk_o),
        .rise    (rise),
        .fall    (fall),
        .div_eff (div_eff)
    );
    // delay clamped to the half-period so a capture never overlaps the next edge event
    always_comb begin
        dmax     = W'(div_eff) - W'(1);
        dly_x    = W'(dly_i);
        dly_eff  = DLY_W'(dly_x > dmax ? dmax : dly_x);
        ev       = (rise && edge_sel(edge_mode_i, 1'b0)) || (fall && edge_sel(edge_mode_i, 1'b1));
        cap_now  = ev && dly_eff == '0;
        cap      = cap_now || (pend && dcnt == DLY_W'(1));
        cap_side = cap_now ? (fall ? SIDE_R : SIDE_L) : side_p;
    end
    always_ff @(posedge clk_i) begin
        if (clr) begin
            pend   <= 1'b0;
            dcnt   <= '0;
            side_p <= SIDE_L;
        end else if (ev && !cap_now) begin
            pend   <= 1'b1;
            dcnt   <= dly_eff;
            side_p <= fall ? SIDE_R : SIDE_L;
        end else if (pend) begin
            pend   <= dcnt != DLY_W'(1);
            dcnt   <= dcnt - DLY_W'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (clr) begin
            data_o  <= '0;
            side_o  <= SIDE_L;
            valid_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else if (cap && (!valid_o || ready_i)) begin
            data_o  <= data_i;
            side_o  <= cap_side;
            valid_o <= 1'b1;
        end else if (cap) begin
            ovf_o   <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_sampler_mc.sv
// tb_pdm_sampler_mc: directed vector table plus hand sequences for overrun, divider change and reset
module tb_pdm_sampler_mc;
    logic       clk_i = 1'b0;
    logic       rst_i, en_i, ready_i;
    logic [7:0] div_i;
    logic [3:0] dly_i;
    logic [1:0] edge_mode_i, data_i, data_o;
    logic       pdm_clk_o, side_o, valid_o, ovf_o;
    int         checks = 0;
    int         failures = 0;

    pdm_sampler_mc #(.NUM_CH(2), .DIV_W(8), .DLY_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .div_i(div_i), .dly_i(dly_i),
        .edge_mode_i(edge_mode_i), .data_i(data_i), .pdm_clk_o(pdm_clk_o), .data_o(data_o),
        .side_o(side_o), .valid_o(valid_o), .ready_i(ready_i), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [7:0] div;
        logic [3:0] dly;
        logic [1:0] mode;
        logic [1:0] data;
        logic       ready;
        int         n;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    // expected output word {pdm_clk, data[1:0], side, valid, ovf}
    function automatic logic [5:0] e(logic p, logic [1:0] d, logic s, logic v, logic o);
        return {p, d, s, v, o};
    endfunction

    function automatic vec_t mk(logic r, logic [7:0] dv, logic [3:0] dl, logic [1:0] m,
                                logic [1:0] d, logic rd, int n, logic [5:0] x);
        vec_t t;
        t.rst = r; t.div = dv; t.dly = dl; t.mode = m; t.data = d; t.ready = rd; t.n = n; t.exp = x;
        return t;
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(string name, logic [5:0] exp);
        logic [5:0] got;
        got = {pdm_clk_o, data_o, side_o, valid_o, ovf_o};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{pdm,data,side,valid,ovf}=%b expected=%b", name, got, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; div_i = 8'd4; dly_i = 4'd0;
        edge_mode_i = 2'b00; data_i = 2'b00;
        // div 4, rising only: capture one cycle after each rise
        vecs.push_back(mk(1, 4, 0, 2'b00, 2'b01, 1, 2, e(0, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 4, 0, 2'b00, 2'b01, 1, 4, e(1, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 4, 0, 2'b00, 2'b01, 1, 1, e(1, 2'b01, 0, 1, 0)));
        vecs.push_back(mk(0, 4, 0, 2'b00, 2'b01, 1, 1, e(1, 2'b01, 0, 0, 0)));
        vecs.push_back(mk(0, 4, 0, 2'b00, 2'b01, 1, 2, e(0, 2'b01, 0, 0, 0)));
        vecs.push_back(mk(0, 4, 0, 2'b00, 2'b01, 1, 5, e(1, 2'b01, 0, 1, 0)));
        vecs.push_back(mk(0, 4, 0, 2'b00, 2'b01, 1, 1, e(1, 2'b01, 0, 0, 0)));
        // div 3, both edges: alternating sides
        vecs.push_back(mk(1, 3, 0, 2'b10, 2'b01, 1, 1, e(0, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b01, 1, 3, e(1, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b10, 1, 1, e(1, 2'b10, 0, 1, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b10, 1, 1, e(1, 2'b10, 0, 0, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b01, 1, 1, e(0, 2'b10, 0, 0, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b01, 1, 1, e(0, 2'b01, 1, 1, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b01, 1, 1, e(0, 2'b01, 1, 0, 0)));
        vecs.push_back(mk(0, 3, 0, 2'b10, 2'b10, 1, 2, e(1, 2'b10, 0, 1, 0)));
        // div 2, dly 7 clamps to 1: capture two cycles after each edge
        vecs.push_back(mk(1, 2, 7, 2'b10, 2'b11, 1, 1, e(0, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 2, 7, 2'b10, 2'b11, 1, 3, e(1, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 2, 7, 2'b10, 2'b11, 1, 1, e(0, 2'b11, 0, 1, 0)));
        vecs.push_back(mk(0, 2, 7, 2'b10, 2'b11, 1, 1, e(0, 2'b11, 0, 0, 0)));
        vecs.push_back(mk(0, 2, 7, 2'b10, 2'b11, 1, 1, e(1, 2'b11, 1, 1, 0)));
        // div 0 acts as 1 (period 2), reserved mode 11 acts as both
        vecs.push_back(mk(1, 0, 7, 2'b11, 2'b10, 1, 1, e(0, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 7, 2'b11, 2'b10, 1, 1, e(1, 2'b00, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 7, 2'b11, 2'b10, 1, 1, e(0, 2'b10, 0, 1, 0)));
        vecs.push_back(mk(0, 0, 7, 2'b11, 2'b10, 1, 1, e(1, 2'b10, 1, 1, 0)));
        vecs.push_back(mk(0, 0, 7, 2'b11, 2'b10, 1, 1, e(0, 2'b10, 0, 1, 0)));
        for (int i = 0; i < vecs.size(); i++) begin
            rst_i = vecs[i].rst; div_i = vecs[i].div; dly_i = vecs[i].dly;
            edge_mode_i = vecs[i].mode; data_i = vecs[i].data; ready_i = vecs[i].ready;
            step(vecs[i].n);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end
        // overrun: ready low holds the first sample, then a coincident capture+ready loads
        rst_i = 1'b1; div_i = 8'd3; dly_i = 4'd0; edge_mode_i = 2'b10; data_i = 2'b10; ready_i = 1'b0;
        step(1);
        rst_i = 1'b0;
        step(4);  chk("ovf_first", e(1, 2'b10, 0, 1, 0));
        data_i = 2'b01;
        step(3);  chk("ovf_set", e(0, 2'b10, 0, 1, 1));
        step(2);  chk("ovf_hold", e(1, 2'b10, 0, 1, 1));
        ready_i = 1'b1;
        step(1);  chk("ovf_noblank", e(1, 2'b01, 0, 1, 1));
        step(1);  chk("ovf_drain", e(1, 2'b01, 0, 0, 1));
        en_i = 1'b0;
        step(1);  chk("en_clear", e(0, 2'b00, 0, 0, 0));
        en_i = 1'b1;
        // reset with a delayed capture pending cancels it
        rst_i = 1'b1; div_i = 8'd4; dly_i = 4'd3; edge_mode_i = 2'b00; data_i = 2'b11;
        step(1);
        rst_i = 1'b0;
        step(6);  chk("pend_before", e(1, 2'b00, 0, 0, 0));
        rst_i = 1'b1;
        step(1);  chk("pend_rst", e(0, 2'b00, 0, 0, 0));
        rst_i = 1'b0;
        step(3);  chk("rel_c3", e(0, 2'b00, 0, 0, 0));
        step(1);  chk("rel_rise", e(1, 2'b00, 0, 0, 0));
        step(1);  chk("rel_c5", e(1, 2'b00, 0, 0, 0));
        step(3);  chk("rel_dly", e(0, 2'b11, 0, 1, 0));
        // divider change mid half-period takes effect at the next toggle
        rst_i = 1'b1; div_i = 8'd4; dly_i = 4'd0; data_i = 2'b01;
        step(1);
        rst_i = 1'b0;
        step(2);
        div_i = 8'd6;
        step(1);  chk("div_c3", e(0, 2'b00, 0, 0, 0));
        step(1);  chk("div_c4", e(1, 2'b00, 0, 0, 0));
        step(5);  chk("div_c9", e(1, 2'b01, 0, 0, 0));
        step(1);  chk("div_c10", e(0, 2'b01, 0, 0, 0));
        step(5);  chk("div_c15", e(0, 2'b01, 0, 0, 0));
        step(1);  chk("div_c16", e(1, 2'b01, 0, 0, 0));
        step(1);  chk("div_c17", e(1, 2'b01, 0, 1, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
